// File: rtl/seg_decode_pkg.sv
// rtl/seg_decode_pkg.sv - glyph constants, digit-count default and output-FSM state for seg_decode_scan
package seg_decode_pkg;

  localparam int NDIG_DEFAULT = 4;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;

  localparam logic [6:0] GLYPH_ALT_6 = 7'h7C;
  localparam logic [6:0] GLYPH_ALT_7 = 7'h27;
  localparam logic [6:0] GLYPH_ALT_9 = 7'h67;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seg_decode_scan_if.sv
// rtl/seg_decode_scan_if.sv - scan input, frame output and handshake bundle for seg_decode_scan
interface seg_decode_scan_if
  import seg_decode_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT
);
  logic [6:0]        seg;
  logic [NDIG-1:0]   dig_en;
  logic              valid;
  logic              ready;
  logic [4*NDIG-1:0] bcd;
  logic [NDIG-1:0]   err;
  logic              ovr;

  modport master (
    output seg, dig_en, ready,
    input  valid, bcd, err, ovr
  );

  modport slave (
    input  seg, dig_en, ready,
    output valid, bcd, err, ovr
  );
endinterface

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - 7-segment pattern to BCD digit; SEG_ALT_GLYPH_EN adds alternate 6/7/9 glyphs
module seg_glyph_decode
  import seg_decode_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_err
);

`ifdef SEG_ALT_GLYPH_EN
  localparam bit ALT_EN = 1'b1;
`else
  localparam bit ALT_EN = 1'b0;
`endif

  always_comb begin
    o_digit = 4'hF;
    o_err   = 1'b1;
    case (i_seg)
      GLYPH_0: begin o_digit = 4'd0; o_err = 1'b0; end
      GLYPH_1: begin o_digit = 4'd1; o_err = 1'b0; end
      GLYPH_2: begin o_digit = 4'd2; o_err = 1'b0; end
      GLYPH_3: begin o_digit = 4'd3; o_err = 1'b0; end
      GLYPH_4: begin o_digit = 4'd4; o_err = 1'b0; end
      GLYPH_5: begin o_digit = 4'd5; o_err = 1'b0; end
      GLYPH_6: begin o_digit = 4'd6; o_err = 1'b0; end
      GLYPH_7: begin o_digit = 4'd7; o_err = 1'b0; end
      GLYPH_8: begin o_digit = 4'd8; o_err = 1'b0; end
      GLYPH_9: begin o_digit = 4'd9; o_err = 1'b0; end
      default: ;
    endcase
    if (ALT_EN) begin
      if (i_seg == GLYPH_ALT_6) begin o_digit = 4'd6; o_err = 1'b0; end
      if (i_seg == GLYPH_ALT_7) begin o_digit = 4'd7; o_err = 1'b0; end
      if (i_seg == GLYPH_ALT_9) begin o_digit = 4'd9; o_err = 1'b0; end
    end
  end

endmodule

// File: rtl/seg_decode_scan.sv
// rtl/seg_decode_scan.sv - debounced multiplexed 7-segment scanner assembling decoded digits into frames
module seg_decode_scan
  import seg_decode_pkg::*;
#(
  parameter int NDIG       = NDIG_DEFAULT,
  parameter int STABLE_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  seg_decode_scan_if.slave bus
);

  localparam logic [3:0] CAP_CNT = 4'(STABLE_CYC - 1);

  logic [6:0]        r_seg_q;
  logic [NDIG-1:0]   r_dig_q;
  logic              r_prev_vld;
  logic [3:0]        r_cnt;
  logic [NDIG-1:0]   r_mask;
  logic [4*NDIG-1:0] r_nib;
  logic [NDIG-1:0]   r_err_stage;
  logic [4*NDIG-1:0] r_bcd;
  logic [NDIG-1:0]   r_err;
  logic              r_valid;
  logic              r_ovr;
  out_state_t        r_state;

  logic              w_same;
  logic [3:0]        w_cnt_nxt;
  logic              w_capture;
  logic [3:0]        w_dec_digit;
  logic              w_dec_err;
  logic [NDIG-1:0]   w_cap_dig;
  logic [NDIG-1:0]   w_mask_nxt;
  logic [4*NDIG-1:0] w_nib_nxt;
  logic [NDIG-1:0]   w_err_nxt;
  logic              w_done;

  // The counter saturates at 15, above any capture point, so each stable interval captures once.
  assign w_same    = r_prev_vld && (bus.seg == r_seg_q) && (bus.dig_en == r_dig_q);
  assign w_cnt_nxt = !w_same ? 4'd0 : ((r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1);
  assign w_capture = (w_cnt_nxt == CAP_CNT) && is_onehot(8'(bus.dig_en));

  seg_glyph_decode u_glyph (
    .i_seg   (bus.seg),
    .o_digit (w_dec_digit),
    .o_err   (w_dec_err)
  );

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign w_cap_dig[g]         = w_capture && bus.dig_en[g];
    assign w_nib_nxt[4*g +: 4]  = w_cap_dig[g] ? w_dec_digit : r_nib[4*g +: 4];
    assign w_err_nxt[g]         = w_cap_dig[g] ? w_dec_err : r_err_stage[g];
  end

  assign w_mask_nxt = r_mask | w_cap_dig;
  assign w_done     = w_capture && (&w_mask_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q     <= '0;
      r_dig_q     <= '0;
      r_prev_vld  <= 1'b0;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_nib       <= '1;
      r_err_stage <= '1;
      r_bcd       <= '1;
      r_err       <= '1;
      r_valid     <= 1'b0;
      r_ovr       <= 1'b0;
      r_state     <= ST_EMPTY;
    end else begin
      r_seg_q     <= bus.seg;
      r_dig_q     <= bus.dig_en;
      r_prev_vld  <= 1'b1;
      r_cnt       <= w_cnt_nxt;
      r_mask      <= w_done ? '0 : w_mask_nxt;
      r_nib       <= w_nib_nxt;
      r_err_stage <= w_err_nxt;
      case (r_state)
        ST_EMPTY: begin
          if (w_done) begin
            r_bcd   <= w_nib_nxt;
            r_err   <= w_err_nxt;
            r_valid <= 1'b1;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          // A frame completing while the held one is unaccepted is dropped.
          if (w_done && bus.ready) begin
            r_bcd <= w_nib_nxt;
            r_err <= w_err_nxt;
          end else if (w_done) begin
            r_ovr <= 1'b1;
          end else if (bus.ready) begin
            r_valid <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.valid = r_valid;
  assign bus.bcd   = r_bcd;
  assign bus.err   = r_err;
  assign bus.ovr   = r_ovr;

endmodule

// File: tb/tb_seg_decode_scan.sv
// tb/tb_seg_decode_scan.sv - randomized and directed self-checking bench for seg_decode_scan
module tb_seg_decode_scan;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic clk;
  logic rst;

  seg_decode_scan_if #(.NDIG(NDIG)) bus ();

  seg_decode_scan #(.NDIG(NDIG), .STABLE_CYC(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         glyph_val [logic [6:0]];
  logic [6:0] glyph_list [$];

  int          m_nib [4];
  bit          m_err_st [4];
  logic [3:0]  m_mask;
  logic        m_valid;
  logic        m_ovr;
  logic [15:0] m_bcd;
  logic [3:0]  m_err;

  function automatic void model_decode(input logic [6:0] s, output int val, output bit e);
    if (glyph_val.exists(s)) begin
      val = glyph_val[s];
      e   = 1'b0;
    end else begin
      val = 15;
      e   = 1'b1;
    end
  endfunction

  // Holds one (seg, dig_en) pair for len cycles; mode 0 ready low, 1 ready high, 2 ready only on last cycle.
  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int len, input int mode);
    bit cap, rdy, comp, e;
    int idx, val;
    cap = (len >= STABLE) && $onehot(d);
    idx = 0;
    for (int k = 0; k < NDIG; k++) if (d[k]) idx = k;
    for (int c = 1; c <= len; c++) begin
      rdy = (mode == 1) || (mode == 2 && c == len);
      bus.seg    = s;
      bus.dig_en = d;
      bus.ready  = rdy;
      @(posedge clk);
      #1;
      comp = 1'b0;
      if (cap && c == STABLE) begin
        model_decode(s, val, e);
        m_nib[idx]    = val;
        m_err_st[idx] = e;
        m_mask[idx]   = 1'b1;
        if (m_mask == 4'hF) begin
          comp   = 1'b1;
          m_mask = 4'h0;
        end
      end
      if (comp && (!m_valid || rdy)) begin
        m_valid = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
          m_bcd[4*k +: 4] = 4'(m_nib[k]);
          m_err[k]        = m_err_st[k];
        end
      end else if (comp) begin
        m_ovr = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    bus.ready = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.ready  = 1'b0;
    bus.seg    = 7'h00;
    bus.dig_en = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_mask  = 4'h0;
    m_bcd   = 16'hFFFF;
    m_err   = 4'hF;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    n_checks++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b want 0", bus.ovr); end
    n_checks++; if (bus.bcd !== 16'hFFFF) begin n_fail++; $display("FAIL reset_bcd got %h want ffff", bus.bcd); end
    n_checks++; if (bus.err !== 4'hF) begin n_fail++; $display("FAIL reset_err got %b want 1111", bus.err); end
  endtask

  task automatic test_basic_scan();
    do_reset();
    hold(7'h06, 4'b0001, 3, 0);
    hold(7'h5B, 4'b0010, 3, 0);
    hold(7'h4F, 4'b0100, 3, 0);
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", bus.valid); end
    hold(7'h66, 4'b1000, 3, 0);
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.valid); end
    n_checks++; if (bus.bcd !== 16'h4321) begin n_fail++; $display("FAIL basic_bcd got %h want 4321", bus.bcd); end
    n_checks++; if (bus.err !== 4'h0) begin n_fail++; $display("FAIL basic_err got %b want 0000", bus.err); end
    n_checks++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL basic_ovr got %b want 0", bus.ovr); end
    hold(7'h00, 4'b0000, 1, 1);
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume got %b want 0", bus.valid); end
  endtask

  task automatic test_short_hold();
    do_reset();
    hold(7'h3F, 4'b0001, 3, 0);
    hold(7'h06, 4'b0010, 3, 0);
    hold(7'h5B, 4'b0100, 2, 0);
    hold(7'h4F, 4'b1000, 3, 0);
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL short_valid got %b want 0", bus.valid); end
    hold(7'h5B, 4'b0100, 3, 0);
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL short_done_valid got %b want 1", bus.valid); end
    n_checks++; if (bus.bcd !== 16'h3210) begin n_fail++; $display("FAIL short_bcd got %h want 3210", bus.bcd); end
  endtask

  task automatic test_alt_glyph();
    logic [15:0] exp_bcd;
    logic [3:0]  exp_err;
`ifdef SEG_ALT_GLYPH_EN
    exp_bcd = 16'h3260;
    exp_err = 4'b0000;
`else
    exp_bcd = 16'h32F0;
    exp_err = 4'b0010;
`endif
    do_reset();
    hold(7'h3F, 4'b0001, 3, 0);
    hold(7'h7C, 4'b0010, 3, 0);
    hold(7'h5B, 4'b0100, 3, 0);
    hold(7'h4F, 4'b1000, 3, 0);
    n_checks++; if (bus.bcd !== exp_bcd) begin n_fail++; $display("FAIL alt_bcd got %h want %h", bus.bcd, exp_bcd); end
    n_checks++; if (bus.err !== exp_err) begin n_fail++; $display("FAIL alt_err got %b want %b", bus.err, exp_err); end
  endtask

  task automatic test_overrun();
    do_reset();
    hold(7'h06, 4'b0001, 3, 0);
    hold(7'h5B, 4'b0010, 3, 0);
    hold(7'h4F, 4'b0100, 3, 0);
    hold(7'h66, 4'b1000, 3, 0);
    hold(7'h7D, 4'b0001, 3, 0);
    hold(7'h07, 4'b0010, 3, 0);
    hold(7'h7F, 4'b0100, 3, 0);
    hold(7'h6F, 4'b1000, 3, 0);
    n_checks++; if (bus.bcd !== 16'h4321) begin n_fail++; $display("FAIL ovr_held_bcd got %h want 4321", bus.bcd); end
    n_checks++; if (bus.ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", bus.ovr); end
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b want 1", bus.valid); end
    hold(7'h66, 4'b0001, 3, 0);
    hold(7'h6D, 4'b0010, 3, 0);
    hold(7'h3F, 4'b0100, 3, 0);
    hold(7'h06, 4'b1000, 3, 2);
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", bus.valid); end
    n_checks++; if (bus.bcd !== 16'h1054) begin n_fail++; $display("FAIL b2b_bcd got %h want 1054", bus.bcd); end
    n_checks++; if (bus.ovr !== 1'b1) begin n_fail++; $display("FAIL b2b_ovr_sticky got %b want 1", bus.ovr); end
    hold(7'h00, 4'b0000, 1, 1);
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_consume got %b want 0", bus.valid); end
  endtask

  task automatic test_strobe_and_reset();
    do_reset();
    hold(7'h06, 4'b0101, 10, 0);
    hold(7'h5B, 4'b0010, 3, 0);
    hold(7'h4F, 4'b1000, 3, 0);
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL multihot_valid got %b want 0", bus.valid); end
    hold(7'h3F, 4'b0001, 3, 0);
    hold(7'h06, 4'b0100, 3, 0);
    do_reset();
    n_checks++; if (bus.bcd !== 16'hFFFF) begin n_fail++; $display("FAIL midreset_bcd got %h want ffff", bus.bcd); end
    n_checks++; if (bus.err !== 4'hF) begin n_fail++; $display("FAIL midreset_err got %b want 1111", bus.err); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", bus.valid); end
    hold(7'h3F, 4'b0001, 3, 0);
    hold(7'h06, 4'b0100, 3, 0);
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL rescan_partial got %b want 0", bus.valid); end
    hold(7'h5B, 4'b0010, 3, 0);
    hold(7'h4F, 4'b1000, 3, 0);
    n_checks++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL rescan_valid got %b want 1", bus.valid); end
    n_checks++; if (bus.bcd !== 16'h3120) begin n_fail++; $display("FAIL rescan_bcd got %h want 3120", bus.bcd); end
  endtask

  task automatic test_random();
    logic [6:0] s, ps;
    logic [3:0] d, pd;
    int r;
    do_reset();
    ps = 7'h00;
    pd = 4'h0;
    for (int n = 0; n < 90; n++) begin
      do begin
        if ($urandom_range(0, 9) < 7) s = glyph_list[$urandom_range(0, glyph_list.size() - 1)];
        else s = 7'($urandom);
        r = $urandom_range(0, 9);
        if (r < 8) d = 4'b0001 << (r % 4);
        else if (r == 8) d = 4'h0;
        else d = 4'($urandom);
      end while (s == ps && d == pd);
      hold(s, d, $urandom_range(1, 5), $urandom_range(0, 3) % 3);
      ps = s;
      pd = d;
      n_checks++; if (bus.valid !== m_valid) begin n_fail++; $display("FAIL rand_valid step %0d got %b want %b", n, bus.valid, m_valid); end
      n_checks++; if (bus.bcd !== m_bcd) begin n_fail++; $display("FAIL rand_bcd step %0d got %h want %h", n, bus.bcd, m_bcd); end
      n_checks++; if (bus.err !== m_err) begin n_fail++; $display("FAIL rand_err step %0d got %b want %b", n, bus.err, m_err); end
      n_checks++; if (bus.ovr !== m_ovr) begin n_fail++; $display("FAIL rand_ovr step %0d got %b want %b", n, bus.ovr, m_ovr); end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.seg    = 7'h00;
    bus.dig_en = 4'h0;
    bus.ready  = 1'b0;
    glyph_val[7'h3F] = 0; glyph_val[7'h06] = 1; glyph_val[7'h5B] = 2; glyph_val[7'h4F] = 3;
    glyph_val[7'h66] = 4; glyph_val[7'h6D] = 5; glyph_val[7'h7D] = 6; glyph_val[7'h07] = 7;
    glyph_val[7'h7F] = 8; glyph_val[7'h6F] = 9;
`ifdef SEG_ALT_GLYPH_EN
    glyph_val[7'h7C] = 6; glyph_val[7'h27] = 7; glyph_val[7'h67] = 9;
`endif
    foreach (glyph_val[k]) glyph_list.push_back(k);
    test_reset();
    test_basic_scan();
    test_short_hold();
    test_alt_glyph();
    test_overrun();
    test_strobe_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_decode_scan.md
SEG_DECODE_SCAN -- requirements
Module: seg_decode_scan

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of multiplexed digits, 1..8.
REQ-002 SHALL have parameter STABLE_CYC, default 3: consecutive identical cycles needed before a capture, 1..15.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port seg  in  7  segment pattern, bit0=a ... bit6=g, 1=lit.
REQ-006 SHALL have port dig_en  in  NDIG  digit strobe, one-hot, active-high; bit i selects digit i.
REQ-007 SHALL have port valid  out  1  output frame available.
REQ-008 SHALL have port ready  in  1  consumer accepts the frame.
REQ-009 SHALL have port bcd  out  4*NDIG  decoded digits; nibble i holds digit i.
REQ-010 SHALL have port err  out  NDIG  per-digit flag: pattern was not a legal glyph.
REQ-011 SHALL have port ovr  out  1  sticky flag: a completed frame was dropped.

Function
REQ-012 SHALL register {seg,dig_en} each cycle; the stability counter increments, saturating, when the current inputs equal the previous cycle's and clears to 0 otherwise.
REQ-013 SHALL capture digit i exactly once per stable interval, on the cycle the counter reaches STABLE_CYC-1, only if dig_en is one-hot with bit i set; zero-hot or multi-hot dig_en never captures.
REQ-014 SHALL decode glyphs a..g: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9.
REQ-015 SHALL decode any other pattern to nibble 4'hF with the digit's err bit set; a legal pattern clears that err bit.
REQ-016 SHALL keep a capture mask; re-capturing a digit before the frame completes overwrites its nibble and err bit.
REQ-017 SHALL complete a frame when the mask becomes all ones; the frame loads into the bcd/err output registers with valid=1 on the next cycle, and the mask clears.
REQ-018 SHALL implement output FSM EMPTY -> FULL on frame load; FULL -> EMPTY on valid&&ready with no frame completing.
REQ-019 SHALL hold bcd and err stable while valid&&!ready.
REQ-020 SHALL, while FULL without ready, discard a newly completed frame and set ovr; the mask still clears.
REQ-021 SHALL, on the same cycle as valid&&ready and a frame completion, load the new frame and keep valid=1 without setting ovr.

Reset
REQ-022 SHALL, on rst, clear valid, ovr, the mask and the counter, set bcd to all 4'hF and err to all ones, and enter EMPTY.
REQ-023 SHALL discard a partially captured frame when rst is asserted mid-scan; stability counting restarts from 0 on the first cycle after reset.

Configuration
REQ-024 SHALL, with SEG_ALT_GLYPH_EN defined, also accept tail-less 6 (0x7C), tail-less 9 (0x67) and serifed 7 (0x27) as legal glyphs.
REQ-025 SHALL, with SEG_ALT_GLYPH_EN undefined, decode 0x7C, 0x67 and 0x27 as illegal (4'hF, err set).

Structure
REQ-026 SHALL place the glyph constants, the NDIG default and the output-FSM state enum in a shared package seg_decode_pkg.
REQ-027 SHALL implement decoding in one combinational sub-module seg_glyph_decode (7-bit pattern in; 4-bit digit and err out).

Verification
REQ-028 SHALL cover: NDIG=4, STABLE_CYC=3; scan glyphs 0x06,0x5B,0x4F,0x66 on digits 0..3, 3 cycles each -> valid next cycle after the last capture, bcd=16'h4321, err=0.
REQ-029 SHALL cover: digit 2 held for only 2 cycles -> no capture, no valid; a later 3-cycle hold completes the frame.
REQ-030 SHALL cover: pattern 0x7C on digit 1 -> nibble 1 = 4'hF, err=4'b0010 without SEG_ALT_GLYPH_EN; nibble 1 = 6, err=0 with it.
REQ-031 SHALL cover: ready held 0 across two completed frames -> first frame stays on bcd, ovr=1; ready=1 on the completion cycle of a third frame -> new frame loaded, valid stays 1.
REQ-032 SHALL cover: dig_en=4'b0101 held 10 cycles -> no capture; rst pulsed after 2 captures -> outputs at reset values, a full 4-digit rescan is required for valid.
